// File: rtl/x_top_rv32i_rf_ctrl.sv
// Core-side access sequencer for the rv32i register file: arbitrates operand reads and
// writebacks onto the single RF slot and returns read data through a buffered response port.
module x_top_rv32i_rf_ctrl #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_rd_req_valid,
  output logic        o_rd_req_ready,
  input  logic [4:0]  i_rd_req_rs1,
  input  logic [4:0]  i_rd_req_rs2,
  output logic        o_rd_rsp_valid,
  input  logic        i_rd_rsp_ready,
  output logic [31:0] o_rd_rsp_rs1_data,
  output logic [31:0] o_rd_rsp_rs2_data,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [4:0]  i_wr_rd,
  input  logic [31:0] i_wr_data,
  output logic        o_rf_wnr,
  output logic [4:0]  o_rf_rs1,
  output logic [4:0]  o_rf_rs2,
  output logic [4:0]  o_rf_rd,
  output logic [31:0] o_rf_rd_data,
  input  logic [31:0] i_rf_rs1_data,
  input  logic [31:0] i_rf_rs2_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LIVE = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e      state_r;
  logic [3:0]  starve_r;
  logic [31:0] hold_rs1_r;
  logic [31:0] hold_rs2_r;
  logic        rsp_valid_r;

  logic wr_real_s;
  logic starved_s;
  logic slot_free_s;
  logic read_cand_s;
  logic force_rd_s;
  logic wr_grant_s;
  logic rd_ready_s;
  logic rd_issue_s;

  // Arbitration of the shared RF slot between writeback and operand read
  always_comb begin
    wr_real_s   = i_wr_valid & (i_wr_rd != 5'd0);
    starved_s   = (starve_r == 4'(STARVE_MAX));
    slot_free_s = (state_r == ST_IDLE) | ((state_r == ST_LIVE) & i_rd_rsp_ready);
    read_cand_s = i_rd_req_valid & slot_free_s;
    force_rd_s  = read_cand_s & starved_s;
    wr_grant_s  = wr_real_s & ~force_rd_s;
    // Ready is formed without i_rd_req_valid so the handshake has no valid->ready loop
    rd_ready_s  = slot_free_s & (~wr_real_s | starved_s);
    rd_issue_s  = i_rd_req_valid & rd_ready_s;
  end

  assign o_rd_req_ready = rd_ready_s;
  assign o_wr_ready     = ~force_rd_s;
  assign o_rd_rsp_valid = rsp_valid_r;

  // RF slot drive: write, read issue, or all-zero idle
  always_comb begin
    o_rf_wnr     = 1'b0;
    o_rf_rd      = 5'd0;
    o_rf_rd_data = 32'd0;
    o_rf_rs1     = 5'd0;
    o_rf_rs2     = 5'd0;
    if (wr_grant_s) begin
      o_rf_wnr     = 1'b1;
      o_rf_rd      = i_wr_rd;
      o_rf_rd_data = i_wr_data;
    end else if (rd_issue_s) begin
      o_rf_rs1 = i_rd_req_rs1;
      o_rf_rs2 = i_rd_req_rs2;
    end else begin
      o_rf_wnr = 1'b0;
    end
  end

  // Response data: live RF data right after issue, buffered copy once backpressured
  always_comb begin
    case (state_r)
      ST_LIVE: begin
        o_rd_rsp_rs1_data = i_rf_rs1_data;
        o_rd_rsp_rs2_data = i_rf_rs2_data;
      end
      ST_HOLD: begin
        o_rd_rsp_rs1_data = hold_rs1_r;
        o_rd_rsp_rs2_data = hold_rs2_r;
      end
      default: begin
        o_rd_rsp_rs1_data = 32'd0;
        o_rd_rsp_rs2_data = 32'd0;
      end
    endcase
  end

  // Response FSM, hold buffer and read-starvation counter
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_r     <= ST_IDLE;
      rsp_valid_r <= 1'b0;
      hold_rs1_r  <= 32'd0;
      hold_rs2_r  <= 32'd0;
      starve_r    <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rd_issue_s) begin
            state_r     <= ST_LIVE;
            rsp_valid_r <= 1'b1;
          end else begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
          end
        end
        ST_LIVE: begin
          if (i_rd_rsp_ready) begin
            state_r     <= rd_issue_s ? ST_LIVE : ST_IDLE;
            rsp_valid_r <= rd_issue_s;
          end else begin
            // RF data is only valid this cycle, so it must be captured now
            hold_rs1_r  <= i_rf_rs1_data;
            hold_rs2_r  <= i_rf_rs2_data;
            state_r     <= ST_HOLD;
            rsp_valid_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (i_rd_rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
          end else begin
            state_r     <= ST_HOLD;
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase

      if (rd_issue_s) begin
        starve_r <= 4'd0;
      end else if (read_cand_s && wr_grant_s && !starved_s) begin
        starve_r <= starve_r + 4'd1;
      end else begin
        starve_r <= starve_r;
      end
    end
  end

endmodule

// File: tb/tb_x_top_rv32i_rf_ctrl.sv
// Scoreboard bench for x_top_rv32i_rf_ctrl: a behavioural RF plus a reference register
// array updated on handshakes; a negedge monitor checks responses and RF-slot drive.
module tb_x_top_rv32i_rf_ctrl;

  localparam int unsigned STARVE_MAX = 4;

  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_rd_req_valid;
  logic        o_rd_req_ready;
  logic [4:0]  i_rd_req_rs1;
  logic [4:0]  i_rd_req_rs2;
  logic        o_rd_rsp_valid;
  logic        i_rd_rsp_ready;
  logic [31:0] o_rd_rsp_rs1_data;
  logic [31:0] o_rd_rsp_rs2_data;
  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [4:0]  i_wr_rd;
  logic [31:0] i_wr_data;
  logic        o_rf_wnr;
  logic [4:0]  o_rf_rs1;
  logic [4:0]  o_rf_rs2;
  logic [4:0]  o_rf_rd;
  logic [31:0] o_rf_rd_data;
  logic [31:0] i_rf_rs1_data;
  logic [31:0] i_rf_rs2_data;

  int checks = 0;
  int errors = 0;

  x_top_rv32i_rf_ctrl #(.STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_rd_req_valid(i_rd_req_valid), .o_rd_req_ready(o_rd_req_ready),
    .i_rd_req_rs1(i_rd_req_rs1), .i_rd_req_rs2(i_rd_req_rs2),
    .o_rd_rsp_valid(o_rd_rsp_valid), .i_rd_rsp_ready(i_rd_rsp_ready),
    .o_rd_rsp_rs1_data(o_rd_rsp_rs1_data), .o_rd_rsp_rs2_data(o_rd_rsp_rs2_data),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_rd(i_wr_rd), .i_wr_data(i_wr_data),
    .o_rf_wnr(o_rf_wnr), .o_rf_rs1(o_rf_rs1), .o_rf_rs2(o_rf_rs2),
    .o_rf_rd(o_rf_rd), .o_rf_rd_data(o_rf_rd_data),
    .i_rf_rs1_data(i_rf_rs1_data), .i_rf_rs2_data(i_rf_rs2_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural register file: write commits at the edge, read data valid next cycle only
  logic [31:0] rf_mem [32];
  initial for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
  always @(posedge i_clk) begin
    if (o_rf_wnr) begin
      if (o_rf_rd != 5'd0) rf_mem[o_rf_rd] <= o_rf_rd_data;
      i_rf_rs1_data <= $urandom;
      i_rf_rs2_data <= $urandom;
    end else begin
      i_rf_rs1_data <= (o_rf_rs1 == 5'd0) ? 32'd0 : rf_mem[o_rf_rs1];
      i_rf_rs2_data <= (o_rf_rs2 == 5'd0) ? 32'd0 : rf_mem[o_rf_rs2];
    end
  end

  // Reference architectural state and expected-response queue
  logic [31:0] ref_rf [32];
  initial for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
  logic [63:0] exp_q [$];
  logic        acc_prev   = 1'b0;
  logic        stall_prev = 1'b0;
  logic [63:0] stall_data;

  // Monitor: sampled mid-cycle while inputs and combinational outputs are settled
  always @(negedge i_clk) begin
    if (!i_nrst) begin
      exp_q.delete();
      acc_prev   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      logic        rd_hs;
      logic        wr_hs;
      logic [63:0] e;
      rd_hs = i_rd_req_valid & o_rd_req_ready;
      wr_hs = i_wr_valid & o_wr_ready;
      if (acc_prev) chk("rsp_latency", {31'd0, o_rd_rsp_valid}, 32'd1);
      if (stall_prev) begin
        chk("rsp_stable_valid", {31'd0, o_rd_rsp_valid}, 32'd1);
        chk("rsp_stable_rs1", o_rd_rsp_rs1_data, stall_data[63:32]);
        chk("rsp_stable_rs2", o_rd_rsp_rs2_data, stall_data[31:0]);
      end
      if (o_rd_rsp_valid && i_rd_rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rs1_data", o_rd_rsp_rs1_data, e[63:32]);
          chk("rsp_rs2_data", o_rd_rsp_rs2_data, e[31:0]);
        end
      end
      stall_prev = o_rd_rsp_valid & ~i_rd_rsp_ready;
      stall_data = {o_rd_rsp_rs1_data, o_rd_rsp_rs2_data};
      chk("rf_rs1_addr", {27'd0, o_rf_rs1}, rd_hs ? {27'd0, i_rd_req_rs1} : 32'd0);
      chk("rf_rs2_addr", {27'd0, o_rf_rs2}, rd_hs ? {27'd0, i_rd_req_rs2} : 32'd0);
      if (rd_hs) exp_q.push_back({ref_rf[i_rd_req_rs1], ref_rf[i_rd_req_rs2]});
      acc_prev = rd_hs;
      chk("rf_wnr", {31'd0, o_rf_wnr}, {31'd0, wr_hs & (i_wr_rd != 5'd0)});
      if (wr_hs && i_wr_rd != 5'd0) begin
        chk("rf_wr_addr", {27'd0, o_rf_rd}, {27'd0, i_wr_rd});
        chk("rf_wr_data", o_rf_rd_data, i_wr_data);
        ref_rf[i_wr_rd] = i_wr_data;
        if (rd_hs) chk("rd_during_write", 32'd1, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_rd(input logic v, input logic [4:0] a, input logic [4:0] b);
    i_rd_req_valid = v; i_rd_req_rs1 = a; i_rd_req_rs2 = b;
  endtask

  task automatic set_wr(input logic v, input logic [4:0] a, input logic [31:0] d);
    i_wr_valid = v; i_wr_rd = a; i_wr_data = d;
  endtask

  task automatic chk_rf_zero(input string name);
    chk({name, "_wnr"}, {31'd0, o_rf_wnr}, 32'd0);
    chk({name, "_rs1"}, {27'd0, o_rf_rs1}, 32'd0);
    chk({name, "_rs2"}, {27'd0, o_rf_rs2}, 32'd0);
    chk({name, "_rd"}, {27'd0, o_rf_rd}, 32'd0);
    chk({name, "_rd_data"}, o_rf_rd_data, 32'd0);
  endtask

  initial begin
    logic rd_hs;
    logic wr_hs;
    i_nrst = 1'b0;
    set_rd(1'b0, 5'd0, 5'd0);
    set_wr(1'b0, 5'd0, 32'd0);
    i_rd_rsp_ready = 1'b1;
    i_rf_rs1_data = 32'd0;
    i_rf_rs2_data = 32'd0;
    tick(); tick();
    chk("reset_rsp_valid", {31'd0, o_rd_rsp_valid}, 32'd0);
    chk_rf_zero("reset_rf");
    i_nrst = 1'b1;
    tick();
    chk("post_reset_rsp_valid", {31'd0, o_rd_rsp_valid}, 32'd0);

    // Write x5 then read it back paired with x0
    set_wr(1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge i_clk);
    chk("wr_x5_wnr", {31'd0, o_rf_wnr}, 32'd1);
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(1'b1, 5'd5, 5'd0);
    @(negedge i_clk);
    chk("rd_x5_ready", {31'd0, o_rd_req_ready}, 32'd1);
    tick();
    set_rd(1'b0, 5'd0, 5'd0);
    @(negedge i_clk);
    chk("rd_x5_rsp", o_rd_rsp_rs1_data, 32'hDEADBEEF);
    tick();

    // x0 write is accepted but never reaches the RF, and a read may share the cycle
    set_wr(1'b1, 5'd0, 32'h00001234);
    set_rd(1'b1, 5'd0, 5'd0);
    @(negedge i_clk);
    chk("wr_x0_ready", {31'd0, o_wr_ready}, 32'd1);
    chk("wr_x0_wnr", {31'd0, o_rf_wnr}, 32'd0);
    chk("wr_x0_rd_ready", {31'd0, o_rd_req_ready}, 32'd1);
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(1'b0, 5'd0, 5'd0);
    @(negedge i_clk);
    chk("rd_x0_rsp", o_rd_rsp_rs1_data, 32'd0);
    tick();

    // Eight back-to-back reads
    for (int i = 0; i < 8; i++) begin
      set_rd(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      @(negedge i_clk);
      chk("b2b_ready", {31'd0, o_rd_req_ready}, 32'd1);
      if (i > 0) chk("b2b_rsp_valid", {31'd0, o_rd_rsp_valid}, 32'd1);
      tick();
    end
    set_rd(1'b0, 5'd0, 5'd0);
    tick();

    // Backpressure: hold x3 response while x3 is overwritten
    set_wr(1'b1, 5'd3, 32'hA5A5A5A5);
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(1'b1, 5'd3, 5'd0);
    i_rd_rsp_ready = 1'b0;
    tick();
    set_rd(1'b1, 5'd4, 5'd3);
    set_wr(1'b1, 5'd3, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("bp_rsp_valid", {31'd0, o_rd_rsp_valid}, 32'd1);
      chk("bp_rsp_data", o_rd_rsp_rs1_data, 32'hA5A5A5A5);
      chk("bp_req_ready", {31'd0, o_rd_req_ready}, 32'd0);
      tick();
      if (i == 1) set_wr(1'b0, 5'd0, 32'd0);
    end
    i_rd_rsp_ready = 1'b1;
    @(negedge i_clk);
    chk("bp_accept_data", o_rd_rsp_rs1_data, 32'hA5A5A5A5);
    chk("bp_accept_req_ready", {31'd0, o_rd_req_ready}, 32'd0);
    tick();
    @(negedge i_clk);
    chk("bp_after_req_ready", {31'd0, o_rd_req_ready}, 32'd1);
    tick();
    set_rd(1'b0, 5'd0, 5'd0);
    tick();

    // Same-cycle write and read of x7: write first, read next cycle sees 0x77
    set_wr(1'b1, 5'd7, 32'h00000077);
    set_rd(1'b1, 5'd7, 5'd0);
    @(negedge i_clk);
    chk("coll_wnr", {31'd0, o_rf_wnr}, 32'd1);
    chk("coll_rd_blocked", {31'd0, o_rd_req_ready}, 32'd0);
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    @(negedge i_clk);
    chk("coll_rd_ready", {31'd0, o_rd_req_ready}, 32'd1);
    tick();
    set_rd(1'b0, 5'd0, 5'd0);
    @(negedge i_clk);
    chk("coll_rsp", o_rd_rsp_rs1_data, 32'h00000077);
    tick();

    // Starvation: continuous writes to x1 block a pending read for STARVE_MAX cycles
    set_rd(1'b1, 5'd1, 5'd2);
    for (int i = 0; i < STARVE_MAX; i++) begin
      set_wr(1'b1, 5'd1, 32'h100 + 32'(i));
      @(negedge i_clk);
      chk("starve_wr_ready", {31'd0, o_wr_ready}, 32'd1);
      chk("starve_rd_blocked", {31'd0, o_rd_req_ready}, 32'd0);
      tick();
    end
    @(negedge i_clk);
    chk("starve_force_wr_ready", {31'd0, o_wr_ready}, 32'd0);
    chk("starve_force_rd_ready", {31'd0, o_rd_req_ready}, 32'd1);
    chk("starve_force_wnr", {31'd0, o_rf_wnr}, 32'd0);
    tick();
    set_rd(1'b0, 5'd0, 5'd0);
    @(negedge i_clk);
    chk("starve_after_wr_ready", {31'd0, o_wr_ready}, 32'd1);
    chk("starve_rsp", o_rd_rsp_rs1_data, 32'h100 + 32'(STARVE_MAX - 1));
    tick();
    set_wr(1'b0, 5'd0, 32'd0);
    tick();

    // Reset while a response is held
    set_rd(1'b1, 5'd5, 5'd7);
    i_rd_rsp_ready = 1'b0;
    tick();
    set_rd(1'b0, 5'd0, 5'd0);
    tick();
    @(negedge i_clk);
    chk("hold_before_reset", {31'd0, o_rd_rsp_valid}, 32'd1);
    tick();
    i_nrst = 1'b0;
    #1;
    chk("mid_reset_rsp_valid", {31'd0, o_rd_rsp_valid}, 32'd0);
    chk_rf_zero("mid_reset_rf");
    tick();
    i_nrst = 1'b1;
    i_rd_rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("post_mid_reset_rsp_valid", {31'd0, o_rd_rsp_valid}, 32'd0);
      tick();
    end

    // Randomized traffic; requests are held until accepted
    for (int n = 0; n < 1500; n++) begin
      @(negedge i_clk);
      rd_hs = i_rd_req_valid & o_rd_req_ready;
      wr_hs = i_wr_valid & o_wr_ready;
      tick();
      if (!i_rd_req_valid || rd_hs)
        set_rd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (!i_wr_valid || wr_hs)
        set_wr(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom);
      i_rd_rsp_ready = ($urandom_range(0, 3) != 0);
    end

    set_rd(1'b0, 5'd0, 5'd0);
    set_wr(1'b0, 5'd0, 32'd0);
    i_rd_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    @(negedge i_clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/x_top_rv32i_rf_ctrl.md
Name: x_top_rv32i_rf_ctrl

Overview:
Access sequencer that drives the rv32i register file (RF) from the core side. It accepts operand-read requests (rs1/rs2 pair) and writeback requests (rd, data), and arbitrates them onto the RF's single shared read-or-write slot. It returns read data through a valid/ready response port with a one-entry hold buffer. Writes to x0 are suppressed, and a starvation counter guarantees read progress.

Parameters:
STARVE_MAX, 4, consecutive cycles a valid read may be blocked by writes before a read is forced (range 1..15).

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_rd_req_valid  in  1  operand-read request valid
o_rd_req_ready  out  1  read request accepted when valid&ready
i_rd_req_rs1  in  5  source register 1 index
i_rd_req_rs2  in  5  source register 2 index
o_rd_rsp_valid  out  1  operand response valid
i_rd_rsp_ready  in  1  consumer accepts response
o_rd_rsp_rs1_data  out  32  rs1 value
o_rd_rsp_rs2_data  out  32  rs2 value
i_wr_valid  in  1  writeback request valid
o_wr_ready  out  1  writeback accepted when valid&ready
i_wr_rd  in  5  destination index
i_wr_data  in  32  writeback data
o_rf_wnr  out  1  RF write-not-read
o_rf_rs1  out  5  RF rs1 address
o_rf_rs2  out  5  RF rs2 address
o_rf_rd  out  5  RF write address
o_rf_rd_data  out  32  RF write data
i_rf_rs1_data  in  32  RF rs1 data, valid the cycle after a read issue
i_rf_rs2_data  in  32  RF rs2 data, valid the cycle after a read issue

Behaviour:
- Clock and reset: single clock i_clk. Reset i_nrst is asynchronous and active-low.
- Reset values: state=IDLE, starve count=0, hold regs=0, o_rd_rsp_valid=0, o_rf_wnr=0, all o_rf_* addresses and data=0.
- RF contract:
  - Read: cycle N drives o_rf_wnr=0 and rs1/rs2; data appears on i_rf_rs*_data in N+1 only.
  - Write: cycle N drives o_rf_wnr=1 with rd and data; the write commits at the N edge.
- Write path:
  - A write with i_wr_rd!=0 that is granted drives o_rf_wnr=1, o_rf_rd=i_wr_rd, o_rf_rd_data=i_wr_data, and blocks any read that cycle.
  - A write with i_wr_rd==0 is accepted (o_wr_ready=1) and dropped. It does not assert o_rf_wnr, and a read may issue in the same cycle.
- o_wr_ready is 1 unless a forced read is granted this cycle (starve count==STARVE_MAX and read can issue).
- Read issue condition: i_rd_req_valid & rsp_slot_free & no non-x0 write granted. Here rsp_slot_free = (state==IDLE) | (state==LIVE & i_rd_rsp_ready). This creates a combinational path from i_rd_rsp_ready to o_rd_req_ready, which is permitted.
- o_rf_rs1/o_rf_rs2 equal the request indices on issue cycles and 0 otherwise.
- States:
  - IDLE: no response outstanding.
  - LIVE: the cycle after issue. o_rd_rsp_valid=1 and response data is driven combinationally from i_rf_rs*_data.
    - If i_rd_rsp_ready: go to LIVE if a new read issues, else IDLE.
    - If not ready: capture RF data into hold regs and go to HOLD.
  - HOLD: o_rd_rsp_valid=1 with data from hold regs. No reads issue; writes continue.
    - On i_rd_rsp_ready: go to IDLE. A new read may issue the following cycle, not the same cycle.
- Latency and throughput: accept at N gives a response at N+1. Back-to-back reads run at 1 per cycle while i_rd_rsp_ready=1 and no writes.
- Response stability: once o_rd_rsp_valid rises, data stays stable until accepted. Writes during LIVE/HOLD do not alter the buffered response, because LIVE data is captured before any RF output change.
- RAW hazard: a same-cycle write and read to the same register means the write goes first and the read issues next cycle, so the read returns the new value.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle i_rd_req_valid & rsp_slot_free & a non-x0 write is granted.
  - Resets to 0 on any read issue.
  - At STARVE_MAX the read is granted and o_wr_ready=0 that cycle.
- Reset mid-operation: any outstanding or held response is discarded, with no o_rd_rsp_valid after release. A write in flight at reset assertion is not guaranteed to commit.

Test Plan:
- Basic write then read:
  - Write x5=0xDEADBEEF, then read rs1=5, rs2=0 → response at issue+1 with rs1_data=0xDEADBEEF, rs2_data=0.
  - Accepted write to x0=0x1234 → o_rf_wnr stays 0; a read of x0 returns 0.
- Back-to-back reads: 8 reads with i_rd_rsp_ready=1 → 8 responses on consecutive cycles, o_rd_req_ready=1 throughout.
- Backpressure:
  - Read x3 (holding 0xA5A5A5A5) with i_rd_rsp_ready=0 for 5 cycles, while writing x3=0x0 during HOLD → response stays 0xA5A5A5A5.
  - o_rd_req_ready=0 until the cycle after acceptance.
- Collision: same-cycle write x7=0x77 and read rs1=7 → write first (o_rf_wnr=1), read next cycle, response 0x77.
- Starvation: continuous i_wr_valid to x1 with a read pending, STARVE_MAX=4 → 4 write cycles, then a read is forced with o_wr_ready=0 for exactly one cycle.
- Reset: assert i_nrst low during HOLD → o_rd_rsp_valid=0 immediately, state=IDLE, and all o_rf_* outputs=0.
